// File: rtl/fb_addr_to_xy_if.sv
// Handshake bundle between an address producer and the fb_addr_to_xy converter.
// The master drives addresses and accepts results; the slave is the converter.
interface fb_addr_to_xy_if #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int ADDR_BITS = 20
);
  localparam int FB_X_BITS = $clog2(FB_WIDTH);
  localparam int FB_Y_BITS = $clog2(FB_HEIGHT);

  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_BITS-1:0] in_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [FB_X_BITS-1:0] out_x;
  logic [FB_Y_BITS-1:0] out_y;
  logic                 out_oob;

  modport master (
    output in_valid, in_addr, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_oob
  );

  modport slave (
    input  in_valid, in_addr, out_ready,
    output in_ready, out_valid, out_x, out_y, out_oob
  );
endinterface

// File: rtl/fb_addr_to_xy.sv
// Linear framebuffer address -> (x, y) pixel coordinates using a bit-serial
// restoring divide by FB_WIDTH; one address in flight, one quotient bit per clock.
module fb_addr_to_xy #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int ADDR_BITS = 20
) (
  input logic            clk,
  input logic            rst_n,
  fb_addr_to_xy_if.slave bus
);
  localparam int FB_X_BITS = $clog2(FB_WIDTH);
  localparam int FB_Y_BITS = $clog2(FB_HEIGHT);
  localparam int CNT_BITS  = $clog2(ADDR_BITS);
  localparam logic [FB_X_BITS:0] DIVISOR = (FB_X_BITS+1)'(FB_WIDTH);
  localparam logic [ADDR_BITS:0] PIXELS  = (ADDR_BITS+1)'(FB_WIDTH * FB_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [FB_X_BITS-1:0] r_out_x;
  logic [FB_Y_BITS-1:0] r_out_y;
  logic                 r_out_oob;
  logic [CNT_BITS-1:0]  r_cnt;

  logic [ADDR_BITS-1:0] r_addr;
  logic [FB_X_BITS-1:0] r_rem;
  logic [FB_Y_BITS-2:0] r_q;
  logic                 r_oob;

  logic                 w_accept;
  logic [FB_X_BITS:0]   w_rem_sh;
  logic                 w_ge;
  logic [FB_X_BITS-1:0] w_rem_nx;
  logic [FB_Y_BITS-1:0] w_q_nx;

  // Quotient bits above FB_Y_BITS are only nonzero for out-of-range addresses,
  // whose coordinates are forced to zero, so they are never kept.
  assign w_accept = bus.in_valid && r_in_ready;
  assign w_rem_sh = {r_rem, r_addr[ADDR_BITS-1]};
  assign w_ge     = (w_rem_sh >= DIVISOR);
  assign w_rem_nx = w_ge ? FB_X_BITS'(w_rem_sh - DIVISOR) : w_rem_sh[FB_X_BITS-1:0];
  assign w_q_nx   = {r_q, w_ge};

  // Divider datapath: loaded on accept, shifted one address bit per DIV cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= bus.in_addr;
      r_rem  <= '0;
      r_q    <= '0;
      r_oob  <= ({1'b0, bus.in_addr} >= PIXELS);
    end else if (r_state == S_DIV) begin
      r_addr <= {r_addr[ADDR_BITS-2:0], 1'b0};
      r_rem  <= w_rem_nx;
      r_q    <= w_q_nx[FB_Y_BITS-2:0];
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_oob   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_cnt      <= CNT_BITS'(ADDR_BITS - 1);
            r_state    <= S_DIV;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == '0) begin
            r_out_x     <= r_oob ? '0 : w_rem_nx;
            r_out_y     <= r_oob ? '0 : w_q_nx;
            r_out_oob   <= r_oob;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;
  assign bus.out_oob   = r_out_oob;
endmodule

// File: tb/tb_fb_addr_to_xy.sv
// Scoreboard bench for fb_addr_to_xy: expected coordinates are pushed when an
// address is accepted and popped when the converter presents a result.
module tb_fb_addr_to_xy;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int AB = 20;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       oob;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;
  res_t sb_q[$];

  fb_addr_to_xy_if #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_BITS(AB)) bus ();

  fb_addr_to_xy #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_BITS(AB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [19:0] a);
    res_t r;
    if (int'(a) >= W * H) begin
      r.x = '0; r.y = '0; r.oob = 1'b1;
    end else begin
      r.x = 10'(int'(a) % W); r.y = 9'(int'(a) / W); r.oob = 1'b0;
    end
    return r;
  endfunction

  task automatic send(input logic [19:0] a, output bit ok);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (ok) sb_q.push_back(model(a));
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    ok = 1'b0; lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = n; ok = 1'b1; break; end
    end
  endtask

  task automatic recv(input int stall, output res_t obs, output int lat, output bit ok);
    wait_valid(lat, ok);
    obs = {bus.out_x, bus.out_y, bus.out_oob};
    if (ok) begin
      repeat (stall) begin @(posedge clk); #1; end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    res_t obs;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.out_x, bus.out_y, bus.out_oob};
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || obs !== '0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h want all 0", bus.in_ready, bus.out_valid, obs);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_points();
    logic [19:0] addrs [6];
    res_t obs, exp;
    int   lat;
    bit   ok, ok2;
    addrs = '{20'd0, 20'd641, 20'd639, 20'd307199, 20'd307200, 20'd1048575};
    for (int i = 0; i < 6; i++) begin
      send(addrs[i], ok);
      recv(0, obs, lat, ok2);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
      n_chk++;
      if (!ok || !ok2 || lat != AB)
        $display("FAIL point_latency addr=%0d: got lat=%0d acc=%b out=%b want lat=%0d", addrs[i], lat, ok, ok2, AB);
      else n_pass++;
      n_chk++;
      if (obs !== exp)
        $display("FAIL point_result addr=%0d: got x=%0d y=%0d oob=%b want x=%0d y=%0d oob=%b",
                 addrs[i], obs.x, obs.y, obs.oob, exp.x, exp.y, exp.oob);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    res_t obs, held, exp;
    int   lat;
    bit   ok, ok2, bad, seen;
    send(20'd1280, ok);
    wait_valid(lat, ok2);
    obs = {bus.out_x, bus.out_y, bus.out_oob};
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_chk++;
    if (!ok || !ok2 || obs !== exp || obs.y !== 9'd2 || obs.x !== 10'd0)
      $display("FAIL bp_result: got x=%0d y=%0d oob=%b want x=0 y=2 oob=0", obs.x, obs.y, obs.oob);
    else n_pass++;
    bus.in_valid = 1'b1;
    bus.in_addr  = 20'd5;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      held = {bus.out_x, bus.out_y, bus.out_oob};
      if (held !== obs || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad) $display("FAIL bp_hold: got x=%0d y=%0d vld=%b rdy=%b want held x=0 y=2 vld=1 rdy=0",
                      held.x, held.y, bus.out_valid, bus.in_ready);
    else n_pass++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    else n_pass++;
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    n_chk++;
    if (seen) $display("FAIL bp_no_queue: got out_valid=1 want 0");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    res_t obs, exp;
    int   lat;
    bit   ok, ok2, seen, bad;
    send(20'd2000, ok);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    seen = 1'b0; bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      obs = {bus.out_x, bus.out_y, bus.out_oob};
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || obs !== '0) bad = 1'b1;
      @(posedge clk);
    end
    n_chk++;
    if (bad) $display("FAIL midreset_outputs: got rdy=%b vld=%b res=%h want all 0", bus.in_ready, bus.out_valid, obs);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    repeat (25) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    n_chk++;
    if (seen) $display("FAIL midreset_aborted: got out_valid=1 want 0");
    else n_pass++;
    send(20'd1279, ok);
    recv(1, obs, lat, ok2);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_chk++;
    if (!ok || !ok2 || obs !== exp || obs.x !== 10'd639 || obs.y !== 9'd1)
      $display("FAIL midreset_after: got x=%0d y=%0d oob=%b want x=639 y=1 oob=0", obs.x, obs.y, obs.oob);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t        obs, exp;
    logic [19:0] a;
    int          lat, stall, n_recv, n_bad;
    bit          ok, ok2;
    n_recv = 0; n_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 20'($urandom % (W * H)) : 20'($urandom);
      stall = $urandom_range(0, 3);
      if (stall == 0) bus.out_ready = 1'b1;
      send(a, ok);
      recv(stall, obs, lat, ok2);
      if (!ok || !ok2) begin
        n_chk++;
        $display("FAIL b2b_timeout addr=%0d: got acc=%b out=%b want 1 1", a, ok, ok2);
        break;
      end
      n_recv++;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
      n_chk++;
      if (obs !== exp || lat != AB) begin
        n_bad++;
        if (n_bad <= 10)
          $display("FAIL b2b_result addr=%0d: got x=%0d y=%0d oob=%b lat=%0d want x=%0d y=%0d oob=%b lat=%0d",
                   a, obs.x, obs.y, obs.oob, lat, exp.x, exp.y, exp.oob, AB);
      end else n_pass++;
    end
    bus.out_ready = 1'b0;
    n_chk++;
    if (n_recv != 1000 || sb_q.size() != 0)
      $display("FAIL b2b_count: got recv=%0d pending=%0d want recv=1000 pending=0", n_recv, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_points();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
